// File: rtl/aes_spi8_pkg.sv
// Shared definitions for the 8-lane parallel SPI receive path:
// block/lane widths, receiver state encoding and synchroniser idle values.
package aes_spi8_pkg;

    localparam int AES_BLOCK_BITS = 128;
    localparam int SPI8_LANES     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    // Idle values loaded into the synchroniser on reset: deselected, strobe low.
    localparam logic                  SYNC_CS_N_RST   = 1'b1;
    localparam logic                  SYNC_STROBE_RST = 1'b0;
    localparam logic [SPI8_LANES-1:0] SYNC_DATA_RST   = '0;

    // Bus order through the shared chain: {cs_n, strobe, data[7:0]}.
    localparam logic [SPI8_LANES+1:0] SYNC_BUS_RST =
        {SYNC_CS_N_RST, SYNC_STROBE_RST, SYNC_DATA_RST};

endpackage

// File: rtl/spi8_sync.sv
// Multi-stage synchroniser over a bus. Every bit runs through the same
// number of flops so bits that change together arrive together.
module spi8_sync #(
    parameter int               WIDTH   = 10,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("spi8_sync: STAGES must be at least 2");
    end

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift the async bus through STAGES flops; reset loads the idle pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/aes_spi8_rx.sv
// Receive end of the AES co-processor 8-lane parallel SPI link.
// Synchronises lanes/strobe/cs_n, assembles BYTES_PER_BLOCK bytes per block
// (first byte in the MSBs) and hands blocks out through a one-entry buffer.
// Optional mid-block watchdog: define AES_SPI8_RX_TIMEOUT_EN.
module aes_spi8_rx
    import aes_spi8_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int BYTES_PER_BLOCK = AES_BLOCK_BITS / SPI8_LANES,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SPI8_LANES-1:0]        spi_data_in,
    input  logic                         spi_clk_in,
    input  logic                         spi_cs_n_in,
    output logic [8*BYTES_PER_BLOCK-1:0] blk_data,
    output logic                         blk_valid,
    input  logic                         blk_ready,
    output logic                         busy,
    output logic                         frame_err,
    output logic                         overflow,
    input  logic                         err_clr,
    output logic [15:0]                  blk_count
);

    localparam int BLK_W = 8 * BYTES_PER_BLOCK;
    localparam int CNT_W = $clog2(BYTES_PER_BLOCK);

    if (BYTES_PER_BLOCK < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("aes_spi8_rx: BYTES_PER_BLOCK must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    // ---------------- synchronisation ----------------
    logic [SPI8_LANES+1:0] sync_q;
    logic                  cs_n_s;
    logic                  stb_s;
    logic [SPI8_LANES-1:0] data_s;

    spi8_sync #(
        .WIDTH   (SPI8_LANES + 2),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SYNC_BUS_RST)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({spi_cs_n_in, spi_clk_in, spi_data_in}),
        .q     (sync_q)
    );

    assign cs_n_s = sync_q[SPI8_LANES+1];
    assign stb_s  = sync_q[SPI8_LANES];
    assign data_s = sync_q[SPI8_LANES-1:0];

    // ---------------- receive state ----------------
    rx_state_t              state;
    logic [CNT_W-1:0]       byte_cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [BLK_W-1:0]       shreg;
    logic                   stb_prev;
    logic                   stb_edge;
    logic                   last_byte;
    logic                   blk_done;
    logic                   cs_armed;
    logic [SYNC_STAGES-1:0] vld_pipe;
    logic                   sync_vld;
    logic                   wdog_fire;
    logic                   fe_set;
    logic                   ov_set;

    // The chain holds reset values for SYNC_STAGES cycles after reset; only
    // once real pin samples come out may a high cs_n arm the receiver.
    assign sync_vld  = vld_pipe[SYNC_STAGES-1];
    assign stb_edge  = stb_s & ~stb_prev;
    assign last_byte = stb_edge && (byte_cnt == CNT_W'(BYTES_PER_BLOCK - 1));

    // Next byte count including this cycle's capture; the cs_n rule is
    // applied to this value so a final byte arriving with cs_n rise counts.
    always_comb begin
        cnt_next = byte_cnt;
        if (stb_edge) begin
            cnt_next = last_byte ? '0 : byte_cnt + 1'b1;
        end
    end

    assign fe_set = (state == RECV) && ((cs_n_s && (cnt_next != '0)) || wdog_fire);
    assign ov_set = blk_done && blk_valid && !blk_ready;
    assign busy   = (state == RECV);

`ifdef AES_SPI8_RX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog;

    assign wdog_fire = (state == RECV) && (byte_cnt != '0) && !stb_edge &&
                       (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    // Count idle cycles while a partial block is pending; restart on each byte.
    always_ff @(posedge clk) begin
        if (reset || stb_edge || state != RECV || byte_cnt == '0 || wdog_fire) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    // Receiver FSM: frame tracking, byte counting, block completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            byte_cnt <= '0;
            stb_prev <= 1'b0;
            blk_done <= 1'b0;
            cs_armed <= 1'b0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
            stb_prev <= stb_s;
            blk_done <= 1'b0;
            if (sync_vld && cs_n_s) begin
                cs_armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cs_armed && !cs_n_s) begin
                        state    <= RECV;
                        byte_cnt <= '0;
                    end
                end
                RECV: begin
                    blk_done <= last_byte;
                    if (cs_n_s) begin
                        state    <= IDLE;
                        byte_cnt <= '0;
                    end else if (wdog_fire) begin
                        byte_cnt <= '0;
                    end else begin
                        byte_cnt <= cnt_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte shift register; a full block overwrites every bit, so no reset.
    always_ff @(posedge clk) begin
        if (state == RECV && stb_edge) begin
            shreg <= {shreg[BLK_W-SPI8_LANES-1:0], data_s};
        end
    end

    // One-entry output buffer, handshake counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_data  <= '0;
            blk_valid <= 1'b0;
            blk_count <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (blk_valid && blk_ready) begin
                blk_count <= blk_count + 1'b1;
            end
            if (blk_done && (!blk_valid || blk_ready)) begin
                blk_data  <= shreg;
                blk_valid <= 1'b1;
            end else if (blk_valid && blk_ready) begin
                blk_valid <= 1'b0;
            end
            frame_err <= fe_set | (frame_err & ~err_clr);
            overflow  <= ov_set | (overflow & ~err_clr);
        end
    end

endmodule

// File: tb/tb_aes_spi8_rx.sv
// Randomised bench for aes_spi8_rx: a queue of expected blocks built from the
// bytes sent, a per-cycle monitor for handshakes/hold/count, and directed
// checks on errors, latency and reset behaviour.
module tb_aes_spi8_rx;

    localparam int SYNC_STAGES = 2;
    localparam int BPB         = 16;
    localparam int TO_CYC      = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   spi_data_in;
    logic         spi_clk_in;
    logic         spi_cs_n_in;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         busy;
    logic         frame_err;
    logic         overflow;
    logic         err_clr;
    logic [15:0]  blk_count;

    aes_spi8_rx #(
        .SYNC_STAGES     (SYNC_STAGES),
        .BYTES_PER_BLOCK (BPB),
        .TIMEOUT_CYCLES  (TO_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_data_in (spi_data_in),
        .spi_clk_in  (spi_clk_in),
        .spi_cs_n_in (spi_cs_n_in),
        .blk_data    (blk_data),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .err_clr     (err_clr),
        .blk_count   (blk_count)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_err    = 0;
    logic [127:0] exp_q[$];
    logic [15:0]  model_count = '0;
    bit           mon_en   = 1'b0;
    bit           rdy_rand = 1'b0;
    logic [7:0]   bytes [32];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Block as the spec defines it: byte i lands at bits [127-8i -: 8].
    function automatic logic [127:0] pack(input int off);
        logic [127:0] b = '0;
        for (int i = 0; i < BPB; i++) b[127-8*i -: 8] = bytes[off+i];
        return b;
    endfunction

    // Per-cycle monitor: count tracking, hold stability, in-order delivery.
    initial begin
        logic [127:0] prev_data = '0;
        bit           prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("blk_count", 128'(blk_count), 128'(model_count));
                if (prev_hold) begin
                    chk("hold_valid", 128'(blk_valid), 128'(1));
                    chk("hold_data", blk_data, prev_data);
                end
                if (reset) begin
                    model_count = '0;
                    exp_q.delete();
                    prev_hold = 1'b0;
                end else begin
                    if (blk_valid && blk_ready) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_err++;
                            $display("FAIL unexpected_block: got %h expected none", blk_data);
                        end else begin
                            chk("blk_data", blk_data, exp_q.pop_front());
                        end
                        model_count = model_count + 16'd1;
                    end
                    prev_hold = blk_valid && !blk_ready;
                    prev_data = blk_data;
                end
            end
        end
    end

    // Random consumer readiness when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) blk_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Overall time bound.
    initial begin
        #500000;
        n_checks++;
        n_err++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "timeout");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One byte: lanes set, strobe low for hold, high for hold. With measure,
    // record the negedge (counted from the strobe drive) where blk_valid rises.
    task automatic send_byte(input logic [7:0] b, input int hold, input bit measure, input bit cs_rise);
        int lat = 0;
        spi_data_in = b;
        cycles(hold);
        spi_clk_in = 1'b1;
        if (cs_rise) spi_cs_n_in = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (measure && lat == 0 && blk_valid) lat = k;
            @(posedge clk);
        end
        #1;
        spi_clk_in = 1'b0;
        // Pin edge -> 2 sync flops -> capture edge -> buffer load edge;
        // sampled on the negedge after the load: 5 negedges.
        if (measure) chk("latency", 128'(lat), 128'(5));
    endtask

    task automatic send_seq(input int off, input int n, input int hold);
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[off+i], (hold > 0) ? hold : int'($urandom_range(3, 6)), 1'b0, 1'b0);
        end
    endtask

    task automatic rand_bytes();
        for (int i = 0; i < 32; i++) bytes[i] = 8'($urandom);
    endtask

    task automatic cs_low();
        spi_cs_n_in = 1'b0;
        cycles(4);
    endtask

    task automatic cs_high();
        spi_cs_n_in = 1'b1;
        cycles(6);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || blk_valid) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk(name, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        reset       = 1'b1;
        spi_data_in = '0;
        spi_clk_in  = 1'b0;
        spi_cs_n_in = 1'b1;
        blk_ready   = 1'b0;
        err_clr     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 128'(blk_valid), 128'(0));
        chk("rst_data", blk_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_frame_err", 128'(frame_err), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
        chk("rst_count", 128'(blk_count), 128'(0));
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        cycles(4);

        // Single block with a hand-computed expectation and latency check.
        blk_ready = 1'b1;
        for (int i = 0; i < 32; i++) bytes[i] = 8'(i);
        exp_q.push_back(128'h000102030405060708090a0b0c0d0e0f);
        cs_low();
        chk("busy_recv", 128'(busy), 128'(1));
        for (int i = 0; i < BPB; i++) send_byte(bytes[i], 8, (i == BPB - 1), 1'b0);
        drain("t1_drain");
        chk("t1_count", 128'(blk_count), 128'(1));
        chk("t1_frame_err", 128'(frame_err), 128'(0));
        chk("t1_overflow", 128'(overflow), 128'(0));
        cs_high();

        // Back-to-back blocks in one frame, random readiness.
        rdy_rand = 1'b1;
        rand_bytes();
        exp_q.push_back(pack(0));
        exp_q.push_back(pack(16));
        cs_low();
        send_seq(0, 32, 0);
        drain("t2_drain");
        cs_high();
        chk("t2_count", 128'(blk_count), 128'(3));
        chk("t2_overflow", 128'(overflow), 128'(0));

        // Backpressure: second block dropped, first held.
        rdy_rand  = 1'b0;
        blk_ready = 1'b0;
        rand_bytes();
        exp_q.push_back(pack(0));
        cs_low();
        send_seq(0, 32, 0);
        cycles(4);
        chk("t3_overflow", 128'(overflow), 128'(1));
        chk("t3_valid", 128'(blk_valid), 128'(1));
        chk("t3_held", blk_data, pack(0));
        chk("t3_frame_err", 128'(frame_err), 128'(0));
        pulse_clr();
        chk("t3_ovf_clr", 128'(overflow), 128'(0));
        blk_ready = 1'b1;
        drain("t3_drain");
        cs_high();
        chk("t3_count", 128'(blk_count), 128'(4));

        // Short frame, then a good frame.
        rdy_rand = 1'b1;
        rand_bytes();
        cs_low();
        send_seq(0, 5, 0);
        cs_high();
        chk("t4_frame_err", 128'(frame_err), 128'(1));
        chk("t4_valid", 128'(blk_valid), 128'(0));
        chk("t4_busy", 128'(busy), 128'(0));
        pulse_clr();
        chk("t4_fe_clr", 128'(frame_err), 128'(0));
        exp_q.push_back(pack(16));
        cs_low();
        send_seq(16, 16, 0);
        drain("t4_drain");
        cs_high();
        chk("t4_count", 128'(blk_count), 128'(5));
        chk("t4_no_err", 128'(frame_err), 128'(0));

        // Reset mid-frame; strobes ignored until cs_n seen high again.
        rand_bytes();
        cs_low();
        send_seq(0, 7, 0);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(2);
        chk("t5_count_rst", 128'(blk_count), 128'(0));
        send_seq(7, 3, 0);
        chk("t5_busy", 128'(busy), 128'(0));
        cs_high();
        chk("t5_no_err", 128'(frame_err), 128'(0));
        exp_q.push_back(pack(16));
        cs_low();
        send_seq(16, 16, 0);
        drain("t5_drain");
        cs_high();
        chk("t5_count", 128'(blk_count), 128'(1));
        chk("t5_frame_err", 128'(frame_err), 128'(0));

        // Final byte and cs_n rise on the same cycle: byte counts, no error.
        rand_bytes();
        exp_q.push_back(pack(0));
        cs_low();
        send_seq(0, 15, 0);
        send_byte(bytes[15], 4, 1'b0, 1'b1);
        drain("t6_drain");
        cycles(4);
        chk("t6_frame_err", 128'(frame_err), 128'(0));
        chk("t6_busy", 128'(busy), 128'(0));
        chk("t6_count", 128'(blk_count), 128'(2));

`ifdef AES_SPI8_RX_TIMEOUT_EN
        // Stalled sender mid-block trips the watchdog; receiver stays in RECV.
        rand_bytes();
        cs_low();
        send_seq(0, 3, 0);
        cycles(TO_CYC + 16);
        chk("t7_frame_err", 128'(frame_err), 128'(1));
        chk("t7_busy", 128'(busy), 128'(1));
        pulse_clr();
        exp_q.push_back(pack(16));
        send_seq(16, 16, 0);
        drain("t7_drain");
        cs_high();
        chk("t7_no_err", 128'(frame_err), 128'(0));
        chk("t7_count", 128'(blk_count), 128'(3));
`endif

        rdy_rand = 1'b0;
        cycles(4);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_spi8_rx.md
Name: aes_spi8_rx

Overview:
Receive end of the 8-lane parallel SPI link driven by the AES co-processor. Synchronises the asynchronous lanes, strobe and chip-select into `clk`. Captures one byte per strobe rising edge while chip-select is low and assembles 16 bytes into one 128-bit ciphertext block. Completed blocks are handed out on a valid/ready port into a one-entry output buffer. Used on the receiving FPGA, or in loopback test fixtures.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on every async input (min 2).
- BYTES_PER_BLOCK, 16, bytes per assembled block; block width = 8*BYTES_PER_BLOCK.
- TIMEOUT_CYCLES, 4096, idle clk cycles mid-block before abort (only with AES_SPI8_RX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- spi_data_in  in  8  parallel data lanes (async).
- spi_clk_in  in  1  byte strobe (async); data valid at rising edge.
- spi_cs_n_in  in  1  chip select, active low (async).
- blk_data  out  128  assembled block; first received byte in [127:120].
- blk_valid  out  1  blk_data valid.
- blk_ready  in  1  consumer accepts when blk_valid&blk_ready.
- busy  out  1  high in state RECV.
- frame_err  out  1  sticky: chip-select rose, or timeout, with partial block.
- overflow  out  1  sticky: block completed while buffer full; block dropped.
- err_clr  in  1  one-cycle pulse clears frame_err and overflow.
- blk_count  out  16  count of blocks delivered (handshakes), wraps at 0xFFFF->0.

Behaviour:
- Reset (sync, high): all sync registers are set to idle values (cs_n=1, strobe=0). State IDLE, byte counter 0, blk_valid 0, blk_data 0, busy 0, frame_err 0, overflow 0, blk_count 0.
- Reset asserted mid-frame discards the partial block. After release the block ignores strobes until chip-select is seen high.
- Synchronisation: data, strobe and cs_n pass through identical SYNC_STAGES chains, so they stay cycle-aligned.
- Strobe edge = synced strobe 1 while the previous synced sample was 0. The sender holds the lanes stable ≥ SYNC_STAGES+1 clk cycles around each rising edge.
- States:
  - IDLE: synced cs_n falls -> RECV, byte counter 0.
  - RECV: each strobe edge shifts the byte into the shift register (left shift, new byte at LSB) and increments the counter.
  - RECV, byte BYTES_PER_BLOCK-1 captured -> counter 0, stay RECV. The block is offered to the buffer; back-to-back blocks within one cs_n frame are legal.
  - RECV, synced cs_n rises with counter≠0 -> frame_err=1, discard partial, IDLE.
  - RECV, synced cs_n rises with counter=0 -> IDLE, no error.
  - Strobe edge while cs_n high: ignored.
  - Strobe edge and cs_n rise in the same cycle: the byte is captured first, then the cs_n rule is applied to the updated counter.
- Output buffer:
  - On block completion, if the buffer is empty, or full and being accepted this cycle, it loads: blk_valid=1 from the next cycle.
  - Otherwise overflow=1, the new block is dropped and the buffer keeps the old block.
  - Latency: strobe rising edge at pin -> byte captured SYNC_STAGES+1 cycles later; blk_valid 1 cycle after the last capture.
  - blk_data is held stable while blk_valid & !blk_ready.
  - Each handshake increments blk_count.
- err_clr in the same cycle as a new error event: the set wins.

Optional Feature:
- Macro AES_SPI8_RX_TIMEOUT_EN.
- Defined:
  - Watchdog counter resets on each strobe edge and counts clk cycles in RECV while counter≠0.
  - Reaching TIMEOUT_CYCLES -> frame_err=1, partial block discarded, counter 0, stay RECV.
- Undefined: no watchdog logic; a stalled sender leaves the partial block pending indefinitely.

Decomposition:
- Shared package aes_spi8_pkg:
  - AES_BLOCK_BITS=128, SPI8_LANES=8.
  - State encoding (IDLE, RECV).
  - Reset values of the sync chains.
- One sub-module: spi8_sync, a parameterised SYNC_STAGES-deep synchroniser over a bus, with a per-bit reset value. It is instantiated once for {cs_n, strobe, data[7:0]} so all bits share one chain.

Test Plan:
- Single block: cs_n low, bytes 0x00..0x0F on 16 strobes (each held 8 clk), blk_ready=1 -> blk_data=0x000102030405060708090A0B0C0D0E0F, one valid pulse, blk_count=1, no errors.
- Back-to-back: 32 bytes in one cs_n frame, blk_ready=1 -> two blocks in order, blk_count=2.
- Backpressure: blk_ready=0 across two complete blocks -> first block held unchanged, overflow=1, second dropped. Then err_clr -> overflow=0.
- Short frame: 5 bytes then cs_n high -> frame_err=1, blk_valid stays 0. Next full 16-byte frame delivers correctly.
- Reset mid-frame: reset after 7 bytes, then 16 bytes in a fresh frame -> block equals only the new 16 bytes.
- With AES_SPI8_RX_TIMEOUT_EN, TIMEOUT_CYCLES=64: 3 bytes then 64 idle cycles -> frame_err=1. A following 16 bytes form a correct block.
